// File: rtl/multicycle_control_if.sv
// Memory handshake between the multicycle controller (master) and the memory system (slave).
// A request stays open until mem_ready is seen in the same cycle as mem_req.
interface multicycle_control_if;
    logic mem_req;
    logic MemRead;
    logic MemWrite;
    logic mem_ready;

    modport master (
        output mem_req,
        output MemRead,
        output MemWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemRead,
        input  MemWrite,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle LEGv8-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait
// timeout into HALT. Optional performance counters are enabled by defining PERF_CNT_EN.
module multicycle_control #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [31:0]          instruction,
    input  logic                 ALUzero,
    multicycle_control_if.master mem,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSrc,
    output logic                 Reg2Loc,
    output logic                 ALUSrc,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 Branch,
    output logic                 UnCondBranch,
    output logic [3:0]           ALUop,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [31:0]          cycle_count,
    output logic [31:0]          instr_count
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } stateT;

    typedef enum logic [3:0] {
        ClsLdur,
        ClsStur,
        ClsAdd,
        ClsSub,
        ClsAnd,
        ClsOrr,
        ClsCbz,
        ClsB,
        ClsIllegal
    } classT;

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOrr   = 4'b0001;
    localparam logic [3:0] AluAdd   = 4'b0010;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluPassB = 4'b0111;

    // Last tolerated wait count; the next not-ready cycle at this value halts the core.
    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    stateT      stateQ, stateD;
    classT      classQ, classD;
    classT      decCls;
    logic [7:0] waitCntQ, waitCntD;

    logic memReq, memRead, memWrite;
    logic irWrite, pcWrite, pcSrc, reg2Loc, aluSrc, memtoReg, regWrite, branch, unCondBranch;
    logic [3:0] aluOp;

    logic unusedInstr;
    assign unusedInstr = ^instruction[20:0];

    always_comb begin
        decCls = ClsIllegal;
        if (instruction[31:21] == 11'h7C2) begin
            decCls = ClsLdur;
        end else if (instruction[31:21] == 11'h7C0) begin
            decCls = ClsStur;
        end else if (instruction[31:21] == 11'h458) begin
            decCls = ClsAdd;
        end else if (instruction[31:21] == 11'h658) begin
            decCls = ClsSub;
        end else if (instruction[31:21] == 11'h450) begin
            decCls = ClsAnd;
        end else if (instruction[31:21] == 11'h550) begin
            decCls = ClsOrr;
        end else if (instruction[31:24] == 8'hB4) begin
            decCls = ClsCbz;
        end else if (instruction[31:26] == 6'h05) begin
            decCls = ClsB;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ   <= StFetch;
            classQ   <= ClsIllegal;
            waitCntQ <= 8'd0;
        end else begin
            stateQ   <= stateD;
            classQ   <= classD;
            waitCntQ <= waitCntD;
        end
    end

    always_comb begin
        stateD       = stateQ;
        classD       = classQ;
        waitCntD     = waitCntQ;
        memReq       = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        pcWrite      = 1'b0;
        pcSrc        = 1'b0;
        reg2Loc      = 1'b0;
        aluSrc       = 1'b0;
        memtoReg     = 1'b0;
        regWrite     = 1'b0;
        branch       = 1'b0;
        unCondBranch = 1'b0;
        aluOp        = 4'b0000;

        unique case (stateQ)
            StFetch: begin
                memReq  = 1'b1;
                memRead = 1'b1;
                if (mem.mem_ready) begin
                    irWrite  = 1'b1;
                    stateD   = StDecode;
                    waitCntD = 8'd0;
                end else if (waitCntQ == WaitLast) begin
                    stateD   = StHalt;
                    waitCntD = 8'd0;
                end else begin
                    waitCntD = waitCntQ + 8'd1;
                end
            end

            StDecode: begin
                // Latch the class so later states do not depend on the instruction bus.
                classD = decCls;
                stateD = (decCls == ClsIllegal) ? StHalt : StExec;
            end

            StExec: begin
                unique case (classQ)
                    ClsAdd, ClsSub, ClsAnd, ClsOrr: begin
                        stateD = StWb;
                        unique case (classQ)
                            ClsAdd:  aluOp = AluAdd;
                            ClsSub:  aluOp = AluSub;
                            ClsAnd:  aluOp = AluAnd;
                            default: aluOp = AluOrr;
                        endcase
                    end
                    ClsLdur, ClsStur: begin
                        aluSrc  = 1'b1;
                        aluOp   = AluAdd;
                        reg2Loc = (classQ == ClsStur);
                        stateD  = StMem;
                    end
                    ClsCbz: begin
                        reg2Loc = 1'b1;
                        aluOp   = AluPassB;
                        branch  = 1'b1;
                        pcWrite = 1'b1;
                        pcSrc   = ALUzero;
                        stateD  = StFetch;
                    end
                    ClsB: begin
                        unCondBranch = 1'b1;
                        pcWrite      = 1'b1;
                        pcSrc        = 1'b1;
                        stateD       = StFetch;
                    end
                    default: stateD = StHalt;
                endcase
            end

            StMem: begin
                memReq   = 1'b1;
                memRead  = (classQ == ClsLdur);
                memWrite = (classQ == ClsStur);
                if (mem.mem_ready) begin
                    waitCntD = 8'd0;
                    if (classQ == ClsStur) begin
                        pcWrite = 1'b1;
                        stateD  = StFetch;
                    end else begin
                        stateD = StWb;
                    end
                end else if (waitCntQ == WaitLast) begin
                    stateD   = StHalt;
                    waitCntD = 8'd0;
                end else begin
                    waitCntD = waitCntQ + 8'd1;
                end
            end

            StWb: begin
                regWrite = 1'b1;
                memtoReg = (classQ == ClsLdur);
                pcWrite  = 1'b1;
                stateD   = StFetch;
            end

            StHalt: stateD = StHalt;

            default: stateD = StHalt;
        endcase
    end

    // Reset forces every strobe low at once, even though the state already reads FETCH.
    always_comb begin
        mem.mem_req  = memReq & reset_n;
        mem.MemRead  = memRead & reset_n;
        mem.MemWrite = memWrite & reset_n;
        IRWrite      = irWrite & reset_n;
        PCWrite      = pcWrite & reset_n;
        PCSrc        = pcSrc & reset_n;
        Reg2Loc      = reg2Loc & reset_n;
        ALUSrc       = aluSrc & reset_n;
        MemtoReg     = memtoReg & reset_n;
        RegWrite     = regWrite & reset_n;
        Branch       = branch & reset_n;
        UnCondBranch = unCondBranch & reset_n;
        ALUop        = aluOp & {4{reset_n}};
    end

    assign state  = stateQ;
    assign halted = (stateQ == StHalt);

`ifdef PERF_CNT_EN
    logic [31:0] cycleCntQ, instrCntQ;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycleCntQ <= 32'd0;
            instrCntQ <= 32'd0;
        end else begin
            if (stateQ != StHalt) begin
                cycleCntQ <= cycleCntQ + 32'd1;
            end
            if (pcWrite) begin
                instrCntQ <= instrCntQ + 32'd1;
            end
        end
    end

    assign cycle_count = cycleCntQ;
    assign instr_count = instrCntQ;
`else
    assign cycle_count = 32'd0;
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams checked
// against a per-instruction phase model (expected state sequence and strobe totals).
module tb_multicycle_control;

    localparam int unsigned WaitMax = 4;
`ifdef PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] instruction;
    logic        ALUzero;
    logic        IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
    logic        Branch, UnCondBranch, halted;
    logic [3:0]  ALUop;
    logic [2:0]  state;
    logic [31:0] cycle_count, instr_count;

    multicycle_control_if memBus ();

    multicycle_control #(
        .WAIT_MAX(WaitMax)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instruction (instruction),
        .ALUzero     (ALUzero),
        .mem         (memBus),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .Reg2Loc     (Reg2Loc),
        .ALUSrc      (ALUSrc),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .Branch      (Branch),
        .UnCondBranch(UnCondBranch),
        .ALUop       (ALUop),
        .state       (state),
        .halted      (halted),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int modelCycles = 0;
    int modelInstr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] strobes();
        return {memBus.mem_req, memBus.MemRead, memBus.MemWrite, IRWrite, PCWrite, PCSrc,
                Reg2Loc, ALUSrc, MemtoReg, RegWrite, Branch, UnCondBranch, ALUop[0] | ALUop[1] |
                ALUop[2] | ALUop[3]};
    endfunction

    // Classes: 0 LDUR, 1 STUR, 2 ADD, 3 SUB, 4 AND, 5 ORR, 6 CBZ, 7 B
    function automatic logic [31:0] makeInstr(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            0:       return {11'h7C2, r[20:0]};
            1:       return {11'h7C0, r[20:0]};
            2:       return {11'h458, r[20:0]};
            3:       return {11'h658, r[20:0]};
            4:       return {11'h450, r[20:0]};
            5:       return {11'h550, r[20:0]};
            6:       return {8'hB4, r[23:0]};
            default: return {6'h05, r[25:0]};
        endcase
    endfunction

    function automatic logic [3:0] expAluOp(input int cls);
        case (cls)
            0, 1, 2: return 4'b0010;
            3:       return 4'b0110;
            4:       return 4'b0000;
            5:       return 4'b0001;
            6:       return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] expCnt(input int v);
        return PerfEn ? 32'(v) : 32'd0;
    endfunction

    // Entered shortly after a rising edge in the instruction's first FETCH cycle.
    task automatic runInstr(input logic [31:0] ins, input int cls, input bit az,
                            input int fw, input int mw);
        int   expSt[$];
        bit   isMem, hasWb, ready;
        int   lat, memEnd;
        int   nRead, nWrite, nReg, nToReg, nBr, nUb, nSrc, nAluSrc, nR2l;
        logic [3:0] execOp;
        isMem  = (cls <= 1);
        hasWb  = (cls == 0) || (cls >= 2 && cls <= 5);
        memEnd = fw + 3 + mw;
        nRead = 0; nWrite = 0; nReg = 0; nToReg = 0; nBr = 0; nUb = 0;
        nSrc = 0; nAluSrc = 0; nR2l = 0;
        execOp = 4'hF;
        for (int i = 0; i <= fw; i++) expSt.push_back(0);
        expSt.push_back(1);
        expSt.push_back(2);
        if (isMem) for (int i = 0; i <= mw; i++) expSt.push_back(3);
        if (hasWb) expSt.push_back(4);
        lat = expSt.size();

        instruction = ins;
        for (int k = 0; k < lat; k++) begin
            if (k <= fw) ready = (k == fw);
            else if (isMem && k >= fw + 3) ready = (k == memEnd);
            else ready = 1'($urandom_range(0, 1));
            memBus.mem_ready = ready;
            ALUzero = az;
            #1;
            chk("state", 32'(state), 32'(expSt[k]));
            chk("mem_req", 32'(memBus.mem_req), 32'(expSt[k] == 0 || expSt[k] == 3));
            chk("IRWrite", 32'(IRWrite), 32'(k == fw));
            chk("PCWrite", 32'(PCWrite), 32'(k == lat - 1));
            nRead   += int'(memBus.MemRead);
            nWrite  += int'(memBus.MemWrite);
            nReg    += int'(RegWrite);
            nToReg  += int'(MemtoReg);
            nBr     += int'(Branch);
            nUb     += int'(UnCondBranch);
            nSrc    += int'(PCSrc);
            nAluSrc += int'(ALUSrc);
            nR2l    += int'(Reg2Loc);
            if (expSt[k] == 2) execOp = ALUop;
            @(posedge clock);
            #1;
        end

        chk("MemRead_cycles", 32'(nRead), 32'(fw + 1 + ((cls == 0) ? mw + 1 : 0)));
        chk("MemWrite_cycles", 32'(nWrite), 32'((cls == 1) ? mw + 1 : 0));
        chk("RegWrite_cycles", 32'(nReg), 32'(hasWb));
        chk("MemtoReg_cycles", 32'(nToReg), 32'(cls == 0));
        chk("Branch_cycles", 32'(nBr), 32'(cls == 6));
        chk("UnCondBranch_cycles", 32'(nUb), 32'(cls == 7));
        chk("PCSrc_cycles", 32'(nSrc), 32'((cls == 6) ? int'(az) : int'(cls == 7)));
        chk("ALUSrc_cycles", 32'(nAluSrc), 32'(isMem));
        chk("Reg2Loc_cycles", 32'(nR2l), 32'(cls == 1 || cls == 6));
        chk("ALUop_exec", 32'(execOp), 32'(expAluOp(cls)));
        modelCycles += lat;
        modelInstr  += 1;
        chk("cycle_count", cycle_count, expCnt(modelCycles));
        chk("instr_count", instr_count, expCnt(modelInstr));
    endtask

    // Entered after a rising edge; leaves in the first cycle after reset release.
    task automatic doReset();
        reset_n = 1'b0;
        memBus.mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_instr_count", instr_count, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("first_fetch_req", 32'({memBus.mem_req, memBus.MemRead}), 32'b11);
        chk("first_fetch_state", 32'(state), 32'd0);
        modelCycles = 0;
        modelInstr  = 0;
    endtask

    initial begin
        int cls, fw, mw;
        bit az;
        reset_n = 1'b1;
        instruction = 32'h0;
        ALUzero = 1'b0;
        memBus.mem_ready = 1'b0;
        @(posedge clock);
        #1;
        doReset();

        // Directed: ADD, delayed LDUR, CBZ taken/not-taken, B, STUR
        runInstr(32'h8B020020, 2, 1'b0, 0, 0);
        runInstr(32'hF8400020, 0, 1'b0, 0, 3);
        runInstr(32'hB4000040, 6, 1'b1, 0, 0);
        runInstr(32'hB4000040, 6, 1'b0, 0, 0);
        runInstr(32'h14000010, 7, 1'b0, 0, 0);
        runInstr(32'hF8000020, 1, 1'b0, 0, 0);
        runInstr(32'hF8000020, 1, 1'b0, 2, 3);

        // Random instruction stream with random wait states below the timeout
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 7);
            fw  = $urandom_range(0, WaitMax - 1);
            mw  = $urandom_range(0, WaitMax - 1);
            az  = 1'($urandom_range(0, 1));
            runInstr(makeInstr(cls), cls, az, fw, mw);
        end

        // Ten zero-wait ADDs from reset
        doReset();
        for (int n = 0; n < 10; n++) runInstr(32'h8B020020, 2, 1'b0, 0, 0);
        chk("perf_instr_10", instr_count, expCnt(10));
        chk("perf_cycle_40", cycle_count, expCnt(40));

        // Illegal opcode halts from DECODE
        doReset();
        instruction = 32'h0;
        memBus.mem_ready = 1'b1;
        #1;
        chk("illegal_irwrite", 32'(IRWrite), 32'd1);
        @(posedge clock);
        #1;
        chk("illegal_decode", 32'(state), 32'd1);
        @(posedge clock);
        #1;
        for (int n = 0; n < 6; n++) begin
            memBus.mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("illegal_halt_state", 32'(state), 32'd7);
            chk("illegal_halted", 32'(halted), 32'd1);
            chk("illegal_strobes", 32'(strobes()), 32'd0);
            chk("illegal_cycles", cycle_count, expCnt(2));
            @(posedge clock);
            #1;
        end

        // Fetch timeout after WaitMax not-ready cycles
        doReset();
        instruction = 32'h8B020020;
        memBus.mem_ready = 1'b0;
        for (int n = 0; n < int'(WaitMax); n++) begin
            #1;
            chk("timeout_fetch_state", 32'(state), 32'd0);
            chk("timeout_irwrite", 32'(IRWrite), 32'd0);
            chk("timeout_mem_req", 32'(memBus.mem_req), 32'd1);
            @(posedge clock);
            #1;
        end
        for (int n = 0; n < 3; n++) begin
            memBus.mem_ready = 1'b1;
            #1;
            chk("timeout_halt_state", 32'(state), 32'd7);
            chk("timeout_halted", 32'(halted), 32'd1);
            chk("timeout_strobes", 32'(strobes()), 32'd0);
            chk("timeout_cycles", cycle_count, expCnt(int'(WaitMax)));
            @(posedge clock);
            #1;
        end

        // Reset in the middle of a STUR memory access
        doReset();
        instruction = 32'hF8000020;
        memBus.mem_ready = 1'b1;
        @(posedge clock);
        #1;
        memBus.mem_ready = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        #1;
        chk("stur_mem_state", 32'(state), 32'd3);
        chk("stur_memwrite", 32'(memBus.MemWrite), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_memwrite", 32'(memBus.MemWrite), 32'd0);
        chk("abort_mem_req", 32'(memBus.mem_req), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        @(posedge clock);
        #1;
        chk("abort_hold_memwrite", 32'(memBus.MemWrite), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("abort_refetch", 32'({memBus.mem_req, memBus.MemRead, memBus.MemWrite}), 32'b110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
